lc3_mem_ctrl: RTL and testbench
===============================

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 3, cycles from request acceptance to R for SRAM accesses (legal 1..15).
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mar  in  16  word address of current access.
REQ-005 mdr_in  in  16  write data from MDR.
REQ-006 mio_en  in  1  access request, held high by control FSM until R.
REQ-007 rw  in  1  1 = write, 0 = read; sampled at acceptance.
REQ-008 mem_out  out  16  read data to MDR.
REQ-009 r  out  1  ready; one-cycle completion pulse.
REQ-010 sram_en / sram_we  out  1 each  SRAM enable / write strobe.
REQ-011 sram_addr / sram_wdata  out  16 each  SRAM address / write data.
REQ-012 sram_rdata  in  16  SRAM read data, valid while sram_en is high with sram_we low.
REQ-013 kbd_valid / kbd_data  in  1 / 8  keyboard character strobe / character.
REQ-014 disp_valid / disp_data  out  1 / 8  display character handshake.
REQ-015 disp_ready  in  1  display accepts the character when high with disp_valid.

Function
REQ-016 FSM states IDLE, WAIT, DONE; IDLE with mio_en=1 accepts: latch mar, mdr_in, rw.
REQ-017 SRAM access: IDLE->WAIT; 4-bit counter loads WAIT_CYCLES-1, decrements each cycle; at 0 -> DONE; WAIT_CYCLES=1 goes IDLE->DONE directly.
REQ-018 r is high exactly in DONE; rising edge of r occurs WAIT_CYCLES cycles after the acceptance edge; DONE -> IDLE unconditionally.
REQ-019 sram_en is high in WAIT and DONE; sram_we = latched rw in those states; sram_addr/sram_wdata are stable from acceptance through DONE.
REQ-020 Read: mem_out captures sram_rdata at the DONE->IDLE edge; mem_out holds until the next read completes; writes do not alter mem_out.
REQ-021 mio_en low in WAIT does not abort; the access completes normally.
REQ-022 Only IDLE accepts, so back-to-back requests have a minimum of one IDLE cycle between them.
REQ-023 mar/mdr_in/rw changes after acceptance are ignored.

Reset
REQ-024 rst low asynchronously forces IDLE, r=0, sram_en=0, sram_we=0, counter=0, mem_out=x0000, disp_valid=0, disp_data=x00, KBSR=x0000, KBDR=x0000, DSR=x8000.
REQ-025 Reset mid-access abandons the access: no r pulse and no SRAM write after release; first acceptance occurs on the first clk edge after rst goes high.

Configuration
REQ-026 Macro LC3_MMIO_EN defined: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR are decoded to device registers, never assert sram_en, and go IDLE->DONE (r one cycle after acceptance).
REQ-027 MMIO registers: kbd_valid sets KBSR[15] and loads KBDR[7:0]; a KBDR read returns KBDR and clears KBSR[15]; a KBSR write stores bit14 only.
REQ-028 MMIO simultaneous events: kbd_valid in the same cycle as a KBDR read returns the old KBDR, loads the new character, and leaves KBSR[15]=1.
REQ-029 A DDR write loads disp_data, sets disp_valid, and clears DSR[15]; disp_valid&&disp_ready clears disp_valid and sets DSR[15]; DDR writes while DSR[15]=0 are dropped.
REQ-030 MMIO register reads return {bit15, bit14, 14'b0} for status registers and {8'b0, data} for data registers.
REQ-031 Macro absent: no address decode, all addresses go to SRAM; kbd inputs are ignored; disp_valid is tied 0 and disp_data is tied x00.

Verification
REQ-032 Default WAIT_CYCLES, read x3000 with sram_rdata=x1234 -> r high 3 cycles after acceptance for 1 cycle; mem_out=x1234 the next cycle.
REQ-033 Write x4000 with data xBEEF, mio_en dropped in WAIT -> sram_we high 3 cycles with addr x4000 and data xBEEF; r pulses once.
REQ-034 rst low in second WAIT cycle -> r never asserts; all outputs at REQ-024 values; a new read after release completes normally.
REQ-035 LC3_MMIO_EN, kbd_valid with x41, then read xFE00 and xFE02 -> x8000 and x0041; a subsequent xFE00 read returns x0000; r latency 1.
REQ-036 LC3_MMIO_EN, write xFE06 with x0058, disp_ready low 4 cycles -> disp_valid high with x58 and xFE04 reads x0000; second DDR write dropped; disp_ready high -> xFE04 reads x8000.

Source files
------------

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: fixed-latency SRAM access with a one-cycle ready pulse.
// Define LC3_MMIO_EN to decode the keyboard/display registers at xFE00..xFE06.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    input  logic        mio_en,
    input  logic        rw,
    output logic [15:0] mem_out,
    output logic        r,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [15:0] addr_q, wdata_q;
    logic        rw_q, mmio_q;
    logic        mmio_hit;
    logic [15:0] mmio_rdata;
    logic        accept;

    assign accept = (state == IDLE) && mio_en;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mio_en) begin
                    if (mmio_hit || WAIT_CYCLES == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            // The cycle that brings the counter to zero is the last WAIT cycle.
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rw_q    <= 1'b0;
            mmio_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q  <= mar;
                wdata_q <= mdr_in;
                rw_q    <= rw;
                mmio_q  <= mmio_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_out <= 16'h0000;
        end else if (state == DONE && !rw_q) begin
            mem_out <= mmio_q ? mmio_rdata : sram_rdata;
        end
    end

    assign r          = (state == DONE);
    assign sram_en    = (state != IDLE) && !mmio_q;
    assign sram_we    = sram_en && rw_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

`ifdef LC3_MMIO_EN
    logic       kbsr_ready, kbsr_ie, dsr_ready;
    logic [7:0] kbdr;
    logic       mmio_rd_done, mmio_wr_done;

    assign mmio_hit = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                      (mar == DSR_ADDR)  || (mar == DDR_ADDR);
    assign mmio_rd_done = (state == DONE) && mmio_q && !rw_q;
    assign mmio_wr_done = (state == DONE) && mmio_q && rw_q;

    always_comb begin
        mmio_rdata = 16'h0000;
        case (addr_q)
            KBSR_ADDR: mmio_rdata = {kbsr_ready, kbsr_ie, 14'b0};
            KBDR_ADDR: mmio_rdata = {8'b0, kbdr};
            DSR_ADDR:  mmio_rdata = {dsr_ready, 1'b0, 14'b0};
            DDR_ADDR:  mmio_rdata = {8'b0, disp_data};
            default:   mmio_rdata = 16'h0000;
        endcase
    end

    // A new keystroke wins over the read-clear so a character is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kbsr_ready <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= 8'h00;
            dsr_ready  <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            if (kbd_valid) begin
                kbsr_ready <= 1'b1;
                kbdr       <= kbd_data;
            end else if (mmio_rd_done && addr_q == KBDR_ADDR) begin
                kbsr_ready <= 1'b0;
            end
            if (mmio_wr_done && addr_q == KBSR_ADDR) begin
                kbsr_ie <= wdata_q[14];
            end
            if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
                dsr_ready  <= 1'b1;
            end else if (mmio_wr_done && addr_q == DDR_ADDR && dsr_ready) begin
                disp_data  <= wdata_q[7:0];
                disp_valid <= 1'b1;
                dsr_ready  <= 1'b0;
            end
        end
    end
`else
    logic unused_inputs;

    assign mmio_hit      = 1'b0;
    assign mmio_rdata    = 16'h0000;
    assign disp_valid    = 1'b0;
    assign disp_data     = 8'h00;
    assign unused_inputs = ^{kbd_valid, kbd_data, disp_ready};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed and random accesses against a
// word-array reference memory; MMIO checks run when LC3_MMIO_EN is defined.
module tb_lc3_mem_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr_in = 16'h0000;
    logic        mio_en = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] mem_out;
    logic        r;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_mem_out = 16'h0000;
    logic [15:0] ref_mem [int];
    logic [15:0] sram_mem [0:65535];

    lc3_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mar(mar), .mdr_in(mdr_in), .mio_en(mio_en),
        .rw(rw), .mem_out(mem_out), .r(r), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: data is only driven while a read is in progress.
    always @(posedge clk) begin
        if (sram_en && sram_we) sram_mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = (sram_en && !sram_we) ? sram_mem[sram_addr] : 16'hDEAD;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one request and watches 10 cycles after acceptance.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                                 input logic drop, input int kbd_k, input logic [7:0] kbd_ch,
                                 output int lat, output int r_cnt, output int we_cnt,
                                 output int en_cnt, output int unstable);
        mar = addr; mdr_in = data; rw = wr; mio_en = 1'b1;
        lat = -1; r_cnt = 0; we_cnt = 0; en_cnt = 0; unstable = 0;
        @(posedge clk); #1;
        mar = 16'($urandom); mdr_in = 16'($urandom); rw = 1'($urandom);
        if (drop) mio_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            kbd_valid = (k == kbd_k);
            if (k == kbd_k) kbd_data = kbd_ch;
            if (r === 1'b1) begin
                r_cnt++;
                if (lat < 0) lat = k;
                mio_en = 1'b0;
            end
            if (sram_en === 1'b1) begin
                en_cnt++;
                if (sram_addr !== addr || (wr && sram_wdata !== data)) unstable++;
            end
            if (sram_we === 1'b1) we_cnt++;
        end
        mio_en = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [15:0] data, input logic drop, input logic mmio,
                            input int kbd_k, input logic [7:0] kbd_ch, input logic [15:0] exp_rd);
        int lat, rc, wc, ec, us;
        applyStimulus(wr, addr, data, drop, kbd_k, kbd_ch, lat, rc, wc, ec, us);
        checkOutput({tag, " latency"}, lat, mmio ? 1 : W);
        checkOutput({tag, " r_pulses"}, rc, 1);
        checkOutput({tag, " en_cycles"}, ec, mmio ? 0 : W);
        checkOutput({tag, " we_cycles"}, wc, (mmio || !wr) ? 0 : W);
        checkOutput({tag, " addr_data_stable"}, us, 0);
        if (!wr) exp_mem_out = exp_rd;
        if (wr && !mmio) ref_mem[int'(addr)] = data;
        checkOutput({tag, " mem_out"}, mem_out, exp_mem_out);
    endtask

    initial begin
        logic [15:0] pool [8];
        int          seen;
        logic        wr, drop;
        logic [15:0] addr, data;

        for (int i = 0; i < 65536; i++) sram_mem[i] = 16'(i) ^ 16'h5A5A;
        pool = '{16'h3000, 16'h4000, 16'h3001, 16'hFFFF, 16'h0000, 16'hFE01, 16'hFE08, 16'h1234};
`ifndef LC3_MMIO_EN
        pool[5] = 16'hFE00;
        pool[6] = 16'hFE06;
`endif

        repeat (2) @(negedge clk);
        checkOutput("reset r", r, 0);
        checkOutput("reset sram_en", sram_en, 0);
        checkOutput("reset sram_we", sram_we, 0);
        checkOutput("reset mem_out", mem_out, 16'h0000);
        checkOutput("reset disp_valid", disp_valid, 0);
        checkOutput("reset disp_data", disp_data, 8'h00);
        rst = 1'b1;

        sram_mem[16'h3000] = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;
        doAccess("read3000", 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, -1, 8'h00, 16'h1234);
        doAccess("write4000", 1'b1, 16'h4000, 16'hBEEF, 1'b1, 1'b0, -1, 8'h00, 16'h0000);
        doAccess("read4000", 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, -1, 8'h00, ref_read(16'h4000));

        for (int n = 0; n < 24; n++) begin
            wr   = 1'($urandom_range(0, 1));
            drop = 1'($urandom_range(0, 1));
            addr = (n % 3 == 2) ? 16'($urandom) : pool[$urandom_range(0, 7)];
`ifdef LC3_MMIO_EN
            if (addr >= 16'hFE00 && addr <= 16'hFE06 && addr[0] == 1'b0) addr = 16'h2000;
`endif
            data = 16'($urandom);
            doAccess($sformatf("rand%0d", n), wr, addr, data, drop, 1'b0, -1, 8'h00, ref_read(addr));
        end

        // Reset in the second WAIT cycle abandons the read.
        mar = 16'h4000; rw = 1'b0; mio_en = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        mio_en = 1'b0;
        checkOutput("midreset r", r, 0);
        checkOutput("midreset sram_en", sram_en, 0);
        checkOutput("midreset sram_we", sram_we, 0);
        checkOutput("midreset mem_out", mem_out, 16'h0000);
        checkOutput("midreset disp_valid", disp_valid, 0);
        exp_mem_out = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r !== 1'b0 || sram_en !== 1'b0) seen++;
        end
        checkOutput("postreset idle", seen, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        doAccess("postreset read", 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, -1, 8'h00, ref_read(16'h4000));

`ifdef LC3_MMIO_EN
        kbd_valid = 1'b1; kbd_data = 8'h41;
        @(negedge clk);
        kbd_valid = 1'b0;
        doAccess("kbsr1", 1'b0, 16'hFE00, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h8000);
        doAccess("kbdr1", 1'b0, 16'hFE02, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h0041);
        doAccess("kbsr2", 1'b0, 16'hFE00, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h0000);
        doAccess("kbdr_sim", 1'b0, 16'hFE02, 16'h0, 1'b0, 1'b1, 1, 8'h42, 16'h0041);
        doAccess("kbsr3", 1'b0, 16'hFE00, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h8000);
        doAccess("kbdr2", 1'b0, 16'hFE02, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h0042);
        doAccess("kbsr_wr", 1'b1, 16'hFE00, 16'hFFFF, 1'b0, 1'b1, -1, 8'h00, 16'h0);
        doAccess("kbsr_ie", 1'b0, 16'hFE00, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h4000);
        disp_ready = 1'b0;
        doAccess("ddr_wr1", 1'b1, 16'hFE06, 16'h0058, 1'b0, 1'b1, -1, 8'h00, 16'h0);
        checkOutput("disp_valid set", disp_valid, 1);
        checkOutput("disp_data set", disp_data, 8'h58);
        doAccess("dsr_busy", 1'b0, 16'hFE04, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h0000);
        doAccess("ddr_wr2", 1'b1, 16'hFE06, 16'h0077, 1'b0, 1'b1, -1, 8'h00, 16'h0);
        checkOutput("ddr dropped", disp_data, 8'h58);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        checkOutput("disp_valid clr", disp_valid, 0);
        doAccess("dsr_ready", 1'b0, 16'hFE04, 16'h0, 1'b0, 1'b1, -1, 8'h00, 16'h8000);
`else
        kbd_valid = 1'b1; kbd_data = 8'h41; disp_ready = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
        doAccess("nommio fe02", 1'b0, 16'hFE02, 16'h0, 1'b0, 1'b0, -1, 8'h00, ref_read(16'hFE02));
        doAccess("nommio fe06", 1'b1, 16'hFE06, 16'h0058, 1'b0, 1'b0, -1, 8'h00, 16'h0);
        checkOutput("nommio disp_valid", disp_valid, 0);
        checkOutput("nommio disp_data", disp_data, 8'h00);
        disp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
